// File: rtl/debug_host.sv
// Host side of a UART debug link: frames a read/write command onto tx, then
// collects the target's reply on rx with per-byte timeout and ack checking.
module debug_host #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_write,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, FINISH} state_t;

  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] TO_END   = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        is_write;
  logic [47:0] tx_frame;
  logic [3:0]  tx_bit;
  logic [2:0]  tx_bytes_left;
  logic [15:0] tx_cnt;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_active;
  logic [3:0]  rx_bit;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_sh;
  logic [2:0]  rx_count;
  logic [31:0] rd_sh;
  logic [31:0] to_cnt;
  logic        err_q;

  logic send_last, rx_stop, byte_ev, frame_err, last_byte, bad_ack, timeout, fail;

  always_comb begin
    send_last = (state == SEND) && (tx_cnt == BIT_END) && (tx_bit == 4'd9) &&
                (tx_bytes_left == 3'd1);
    rx_stop   = rx_active && (rx_bit == 4'd9) && (rx_cnt == BIT_END);
    byte_ev   = rx_stop && rx_s2;
    frame_err = rx_stop && !rx_s2;
    last_byte = byte_ev && (rx_count == (is_write ? 3'd0 : 3'd3));
    bad_ack   = byte_ev && is_write && (rx_sh != 8'hAA);
    timeout   = (to_cnt == TO_END);
    fail      = frame_err || bad_ack || timeout;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = SEND;
      SEND:      if (send_last) state_nxt = WAIT_RESP;
      WAIT_RESP: if (fail || last_byte) state_nxt = FINISH;
      default:   state_nxt = IDLE;
    endcase
  end

  // Transmitter: tx is registered so each bit holds for exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx <= 1'b1; tx_frame <= '0; tx_bit <= '0; tx_bytes_left <= '0; tx_cnt <= '0;
      is_write <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        tx_frame      <= {wdata, 6'b0, reg_sel, cmd_write ? 8'h01 : 8'h02};
        is_write      <= cmd_write;
        tx_bytes_left <= cmd_write ? 3'd6 : 3'd2;
        tx_bit        <= '0;
        tx_cnt        <= '0;
        tx            <= 1'b0;
      end
    end else if (state == SEND) begin
      if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          if (tx_bytes_left != 3'd1) begin
            tx_frame      <= tx_frame >> 8;
            tx_bytes_left <= tx_bytes_left - 3'd1;
            tx_bit        <= '0;
            tx            <= 1'b0;
          end
        end else begin
          tx_bit <= tx_bit + 4'd1;
          tx     <= (tx_bit == 4'd8) ? 1'b1 : tx_frame[tx_bit[2:0]];
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // Receiver: the start bit is re-checked at half a bit so short glitches are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      rx_active <= 1'b0; rx_bit <= '0; rx_cnt <= '0; rx_sh <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (state != WAIT_RESP) begin
        rx_active <= 1'b0;
      end else if (!rx_active) begin
        if (rx_prev && !rx_s2) begin
          rx_active <= 1'b1; rx_cnt <= '0; rx_bit <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          if (rx_s2) rx_active <= 1'b0;
          else       rx_bit    <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 16'd1;
        end
      end else if (rx_cnt == BIT_END) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) rx_active <= 1'b0;
        else begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count <= '0; rd_sh <= '0; to_cnt <= '0; err_q <= 1'b0; rdata <= '0;
    end else if (send_last) begin
      rx_count <= '0;
      to_cnt   <= '0;
    end else if (state == WAIT_RESP) begin
      if (byte_ev) begin
        to_cnt   <= '0;
        rx_count <= rx_count + 3'd1;
        rd_sh    <= {rx_sh, rd_sh[31:8]};
      end else begin
        to_cnt <= to_cnt + 32'd1;
      end
      if (fail || last_byte) err_q <= fail;
      if (last_byte && !fail && !is_write) rdata <= {rx_sh, rd_sh[31:8]};
    end
  end

  assign busy  = (state == SEND) || (state == WAIT_RESP);
  assign done  = (state == FINISH) && !err_q;
  assign error = (state == FINISH) && err_q;
endmodule

// File: tb/tb_debug_host.sv
// Directed bench for debug_host: decodes the tx frame, plays the target on rx.
module tb_debug_host;
  localparam int CPB = 8;
  localparam int TO  = 300;

  logic        clk = 1'b0;
  logic        reset, start, cmd_write, rx;
  logic [1:0]  reg_sel;
  logic [31:0] wdata, rdata;
  logic        busy, done, error, tx;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  debug_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_write(cmd_write), .reg_sel(reg_sel),
    .wdata(wdata), .busy(busy), .done(done), .error(error), .rdata(rdata), .tx(tx), .rx(rx)
  );

  task automatic get_byte(output logic [7:0] b, output bit ok);
    int t = 0;
    ok = 1'b1; b = '0;
    while (tx !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin ok = 1'b0; return; end
    repeat (CPB/2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); b[i] = tx; end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (CPB) @(negedge clk); end
    rx = stop_v;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic issue(input logic w, input logic [1:0] rs, input logic [31:0] wd);
    @(negedge clk);
    start = 1'b1; cmd_write = w; reg_sel = rs; wdata = wd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output int cyc, output logic d, output logic e);
    cyc = 0; d = 1'b0; e = 1'b0;
    while (cyc < 5000) begin
      @(negedge clk); cyc++;
      if (done === 1'b1 || error === 1'b1) begin d = done; e = error; return; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; cmd_write = 1'b0; reg_sel = '0; wdata = '0; rx = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (tx !== 1'b1)  begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    logic [7:0] exp_b [6] = '{8'h01, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] b; bit ok; int cyc; logic d, e;
    issue(1'b1, 2'd2, 32'hDEADBEEF);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", busy); end
    start = 1'b1; cmd_write = 1'b0;     // request while busy must be dropped
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      get_byte(b, ok);
      n_chk++;
      if (!ok || b !== exp_b[i]) begin
        n_fail++; $display("FAIL write_byte%0d: got %h ok=%0d expected %h", i, b, ok, exp_b[i]);
      end
    end
    repeat (CPB) @(negedge clk);
    fork
      send_byte(8'hAA, 1'b1);
      wait_end(cyc, d, e);
    join
    n_chk++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL write_done: got done=%b error=%b expected 1/0", d, e); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_fall: got %b expected 0", busy); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL write_done_pulse: got %b expected 0", done); end
    repeat (5) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_no_queue: got busy=%b expected 0", busy); end
  endtask

  task automatic test_read;
    logic [7:0] b0, b1; bit ok0, ok1; int cyc; logic d, e;
    issue(1'b0, 2'd1, 32'h0);
    get_byte(b0, ok0); get_byte(b1, ok1);
    n_chk++; if (!ok0 || !ok1 || b0 !== 8'h02 || b1 !== 8'h01) begin
      n_fail++; $display("FAIL read_frame: got %h %h expected 02 01", b0, b1); end
    repeat (CPB) @(negedge clk);
    fork
      begin send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1); end
      wait_end(cyc, d, e);
    join
    n_chk++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL read_done: got done=%b error=%b expected 1/0", d, e); end
    n_chk++; if (rdata !== 32'h12345678) begin n_fail++; $display("FAIL read_rdata: got %h expected 12345678", rdata); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bad_ack;
    logic [7:0] b; bit ok; int cyc; logic d, e;
    issue(1'b1, 2'd0, 32'h11223344);
    for (int i = 0; i < 6; i++) get_byte(b, ok);
    repeat (CPB) @(negedge clk);
    fork
      send_byte(8'h55, 1'b1);
      wait_end(cyc, d, e);
    join
    n_chk++; if (e !== 1'b1 || d !== 1'b0) begin n_fail++; $display("FAIL bad_ack: got done=%b error=%b expected 0/1", d, e); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout;
    int k = 0;
    issue(1'b0, 2'd3, 32'h0);
    while (k < 2000) begin
      @(negedge clk); k++;
      if (error === 1'b1 || done === 1'b1) break;
    end
    n_chk++; if (k != 20*CPB + TO) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", k, 20*CPB + TO); end
    n_chk++; if (error !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: got done=%b error=%b expected 0/1", done, error); end
    n_chk++; if (rdata !== 32'h12345678) begin n_fail++; $display("FAIL timeout_rdata: got %h expected 12345678", rdata); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame_err;
    logic [7:0] b; bit ok; int cyc; logic d, e;
    issue(1'b0, 2'd0, 32'h0);
    get_byte(b, ok); get_byte(b, ok);
    repeat (CPB) @(negedge clk);
    fork
      begin send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b0); end
      wait_end(cyc, d, e);
    join
    n_chk++; if (e !== 1'b1 || d !== 1'b0) begin n_fail++; $display("FAIL frame_err: got done=%b error=%b expected 0/1", d, e); end
    n_chk++; if (rdata !== 32'h12345678) begin n_fail++; $display("FAIL frame_err_rdata: got %h expected 12345678", rdata); end
    repeat (3 * 10 * CPB) @(negedge clk);
  endtask

  task automatic test_glitch;
    logic [7:0] b; bit ok; int cyc; logic d, e;
    issue(1'b0, 2'd2, 32'h0);
    get_byte(b, ok); get_byte(b, ok);
    repeat (CPB) @(negedge clk);
    rx = 1'b0; @(negedge clk); rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    n_chk++; if (busy !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL glitch: got busy=%b error=%b expected 1/0", busy, error); end
    fork
      begin send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1); end
      wait_end(cyc, d, e);
    join
    n_chk++; if (d !== 1'b1 || rdata !== 32'h44332211) begin n_fail++; $display("FAIL glitch_read: got done=%b rdata=%h expected 1/44332211", d, rdata); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_b [6] = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    logic [7:0] b; bit ok; int cyc; logic d, e; logic seen = 1'b0;
    issue(1'b1, 2'd1, 32'h5A5A5A5A);
    get_byte(b, ok); get_byte(b, ok);
    repeat (3 * CPB) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid: got tx=%b busy=%b expected 1/0", tx, busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) begin @(negedge clk); if (done === 1'b1 || error === 1'b1) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mid_quiet: got pulse=%b rdata=%h expected 0/0", seen, rdata); end
    issue(1'b1, 2'd0, 32'h01020304);
    for (int i = 0; i < 6; i++) begin
      get_byte(b, ok);
      n_chk++;
      if (!ok || b !== exp_b[i]) begin
        n_fail++; $display("FAIL rewrite_byte%0d: got %h ok=%0d expected %h", i, b, ok, exp_b[i]);
      end
    end
    repeat (CPB) @(negedge clk);
    fork
      send_byte(8'hAA, 1'b1);
      wait_end(cyc, d, e);
    join
    n_chk++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL rewrite_done: got done=%b error=%b expected 1/0", d, e); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_bad_ack;
    test_timeout;
    test_frame_err;
    test_glitch;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
